// File: rtl/adder_sum_accumulator_if.sv
// rtl/adder_sum_accumulator_if.sv - sample-in / block-result-out handshake bundle for the sum accumulator
interface adder_sum_accumulator_if #(
    parameter int IN_W  = 9,
    parameter int ACC_W = 16,
    parameter int CNT_W = 8
);
    logic             in_valid;
    logic             in_ready;
    logic [IN_W-1:0]  in_data;
    logic             flush;
    logic             out_valid;
    logic             out_ready;
    logic [ACC_W-1:0] out_sum;
    logic [CNT_W-1:0] out_count;
    logic             out_sat;

    modport master (
        output in_valid, in_data, flush, out_ready,
        input  in_ready, out_valid, out_sum, out_count, out_sat
    );

    modport slave (
        input  in_valid, in_data, flush, out_ready,
        output in_ready, out_valid, out_sum, out_count, out_sat
    );
endinterface

// File: rtl/adder_sum_accumulator.sv
// rtl/adder_sum_accumulator.sv - accumulates adder sums into fixed-length blocks with saturating totals
module adder_sum_accumulator #(
    parameter int IN_W      = 9,
    parameter int ACC_W     = 16,
    parameter int BLOCK_LEN = 4,
    parameter int CNT_W     = 8
) (
    input  logic                    clk,
    input  logic                    reset,
    adder_sum_accumulator_if.slave  bus
);

    typedef enum logic [0:0] {
        ACCUM = 1'b0,
        HOLD  = 1'b1
    } state_t;

    localparam logic [ACC_W:0]   ACC_MAX_EXT = {1'b0, {ACC_W{1'b1}}};
    localparam logic [CNT_W-1:0] BLOCK_CNT   = CNT_W'(BLOCK_LEN);
    localparam logic [CNT_W-1:0] CNT_ONE     = CNT_W'(1);

    state_t           state;
    state_t           state_next;
    logic [ACC_W-1:0] acc;
    logic [ACC_W-1:0] acc_next;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_next;
    logic             sat;
    logic             sat_next;
    logic [ACC_W:0]   sum_ext;
    logic             take;
    logic             close;

    // State register; reset always returns to collecting a fresh block.
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= ACCUM;
        end else begin
            state <= state_next;
        end
    end

    // Next state, saturating add and block-close decision; handshake flags come from state alone.
    always_comb begin
        state_next    = state;
        take          = 1'b0;
        close         = 1'b0;
        acc_next      = acc;
        cnt_next      = cnt;
        sat_next      = sat;
        sum_ext       = {1'b0, acc} + {{(ACC_W + 1 - IN_W){1'b0}}, bus.in_data};
        bus.in_ready  = (state == ACCUM);
        bus.out_valid = (state == HOLD);
        case (state)
            ACCUM: begin
                take = bus.in_valid;
                if (take) begin
                    if (sum_ext > ACC_MAX_EXT) begin
                        acc_next = {ACC_W{1'b1}};
                        sat_next = 1'b1;
                    end else begin
                        acc_next = sum_ext[ACC_W-1:0];
                    end
                    cnt_next = cnt + CNT_ONE;
                end
                // A flush only closes a block that would contain at least one sample.
                close = (take && (cnt_next == BLOCK_CNT)) ||
                        (bus.flush && ((cnt != '0) || take));
                if (close) begin
                    state_next = HOLD;
                end
            end
            HOLD: begin
                if (bus.out_ready) begin
                    state_next = ACCUM;
                end
            end
            default: begin
                state_next = ACCUM;
            end
        endcase
    end

    // Running totals and the result registers; results stay put after the handshake.
    always_ff @(posedge clk) begin
        if (reset) begin
            acc           <= '0;
            cnt           <= '0;
            sat           <= 1'b0;
            bus.out_sum   <= '0;
            bus.out_count <= '0;
            bus.out_sat   <= 1'b0;
        end else if (close) begin
            acc           <= '0;
            cnt           <= '0;
            sat           <= 1'b0;
            bus.out_sum   <= acc_next;
            bus.out_count <= cnt_next;
            bus.out_sat   <= sat_next;
        end else begin
            acc <= acc_next;
            cnt <= cnt_next;
            sat <= sat_next;
        end
    end

endmodule

// File: tb/tb_adder_sum_accumulator.sv
// tb/tb_adder_sum_accumulator.sv - self-checking bench for adder_sum_accumulator at ACC_W=16 and ACC_W=10
module tb_adder_sum_accumulator;

    localparam int BLOCK_LEN = 4;
    localparam int CAP0      = 65535;
    localparam int CAP1      = 1023;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       in_valid = 1'b0;
    logic [8:0] in_data = '0;
    logic       flush = 1'b0;
    logic       out_ready = 1'b1;

    int tests = 0;
    int fails = 0;

    adder_sum_accumulator_if #(.IN_W(9), .ACC_W(16), .CNT_W(8)) if0 ();
    adder_sum_accumulator_if #(.IN_W(9), .ACC_W(10), .CNT_W(8)) if1 ();

    assign if0.in_valid  = in_valid;
    assign if0.in_data   = in_data;
    assign if0.flush     = flush;
    assign if0.out_ready = out_ready;
    assign if1.in_valid  = in_valid;
    assign if1.in_data   = in_data;
    assign if1.flush     = flush;
    assign if1.out_ready = out_ready;

    adder_sum_accumulator #(.IN_W(9), .ACC_W(16), .BLOCK_LEN(BLOCK_LEN), .CNT_W(8)) u0 (
        .clk   (clk),
        .reset (reset),
        .bus   (if0)
    );

    adder_sum_accumulator #(.IN_W(9), .ACC_W(10), .BLOCK_LEN(BLOCK_LEN), .CNT_W(8)) u1 (
        .clk   (clk),
        .reset (reset),
        .bus   (if1)
    );

    always #5 clk = ~clk;

    // Reference model: block contents kept as a list, result computed when the block closes.
    int q[$];
    bit m_live = 1'b0;
    bit m_busy = 1'b0;
    bit m_took = 1'b0;
    int e_sum0 = 0;
    int e_sum1 = 0;
    int e_count = 0;
    bit e_sat0 = 1'b0;
    bit e_sat1 = 1'b0;

    initial begin
        forever begin
            @(posedge clk);
            if (reset) begin
                q.delete();
                m_busy  = 1'b0;
                m_took  = 1'b0;
                e_sum0  = 0;
                e_sum1  = 0;
                e_count = 0;
                e_sat0  = 1'b0;
                e_sat1  = 1'b0;
                m_live  = 1'b1;
            end else if (m_live) begin
                m_took = 1'b0;
                if (m_busy) begin
                    if (out_ready) m_busy = 1'b0;
                end else begin
                    if (in_valid) begin
                        q.push_back(int'(in_data));
                        m_took = 1'b1;
                    end
                    if (q.size() == BLOCK_LEN || (flush && q.size() > 0)) begin
                        int total;
                        total = 0;
                        foreach (q[i]) total += q[i];
                        e_sum0  = (total > CAP0) ? CAP0 : total;
                        e_sat0  = (total > CAP0);
                        e_sum1  = (total > CAP1) ? CAP1 : total;
                        e_sat1  = (total > CAP1);
                        e_count = q.size();
                        q.delete();
                        m_busy  = 1'b1;
                    end
                end
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Every-cycle comparison of both instances against the model.
    initial begin
        forever begin
            @(negedge clk);
            if (m_live && !reset) begin
                chk("u0_out_valid", 32'(if0.out_valid), 32'(m_busy));
                chk("u0_in_ready",  32'(if0.in_ready),  32'(!m_busy));
                chk("u0_out_sum",   32'(if0.out_sum),   32'(e_sum0));
                chk("u0_out_count", 32'(if0.out_count), 32'(e_count));
                chk("u0_out_sat",   32'(if0.out_sat),   32'(e_sat0));
                chk("u1_out_valid", 32'(if1.out_valid), 32'(m_busy));
                chk("u1_in_ready",  32'(if1.in_ready),  32'(!m_busy));
                chk("u1_out_sum",   32'(if1.out_sum),   32'(e_sum1));
                chk("u1_out_count", 32'(if1.out_count), 32'(e_count));
                chk("u1_out_sat",   32'(if1.out_sat),   32'(e_sat1));
            end
        end
    end

    task automatic drive(input logic v, input logic [8:0] d, input logic f, input logic r);
        in_valid  = v;
        in_data   = d;
        flush     = f;
        out_ready = r;
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset = 1'b1;
        @(posedge clk);
        @(posedge clk);
        #1;
        reset = 1'b0;
        chk("rst_out_valid", 32'(if0.out_valid), 32'd0);
        chk("rst_in_ready",  32'(if0.in_ready),  32'd1);
        chk("rst_out_sum",   32'(if0.out_sum),   32'd0);
        chk("rst_out_count", 32'(if0.out_count), 32'd0);

        drive(1'b1, 9'd5,   1'b0, 1'b1);
        drive(1'b1, 9'd7,   1'b0, 1'b1);
        drive(1'b1, 9'd510, 1'b0, 1'b1);
        drive(1'b1, 9'd1,   1'b0, 1'b1);
        chk("blk1_valid", 32'(if0.out_valid), 32'd1);
        chk("blk1_sum",   32'(if0.out_sum),   32'd523);
        chk("blk1_count", 32'(if0.out_count), 32'd4);
        chk("blk1_sat",   32'(if0.out_sat),   32'd0);
        drive(1'b0, 9'd0, 1'b0, 1'b1);
        chk("blk1_ready_after", 32'(if0.in_ready),  32'd1);
        chk("blk1_valid_after", 32'(if0.out_valid), 32'd0);
        chk("blk1_sum_kept",    32'(if0.out_sum),   32'd523);

        for (int i = 0; i < 4; i++) drive(1'b1, 9'd511, 1'b0, 1'b1);
        chk("sat_u1_sum", 32'(if1.out_sum), 32'd1023);
        chk("sat_u1_sat", 32'(if1.out_sat), 32'd1);
        chk("sat_u1_cnt", 32'(if1.out_count), 32'd4);
        chk("sat_u0_sum", 32'(if0.out_sum), 32'd2044);
        chk("sat_u0_sat", 32'(if0.out_sat), 32'd0);
        drive(1'b0, 9'd0, 1'b0, 1'b1);
        for (int i = 0; i < 4; i++) drive(1'b1, 9'd1, 1'b0, 1'b1);
        chk("unsat_u1_sum", 32'(if1.out_sum), 32'd4);
        chk("unsat_u1_sat", 32'(if1.out_sat), 32'd0);
        drive(1'b0, 9'd0, 1'b0, 1'b1);

        for (int i = 1; i <= 4; i++) drive(1'b1, 9'(i), 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 9'd9, 1'b0, 1'b0);
            chk("bp_valid", 32'(if0.out_valid), 32'd1);
            chk("bp_sum",   32'(if0.out_sum),   32'd10);
            chk("bp_ready", 32'(if0.in_ready),  32'd0);
        end
        drive(1'b1, 9'd9, 1'b0, 1'b1);
        chk("bp_hs_valid", 32'(if0.out_valid), 32'd0);
        chk("bp_hs_ready", 32'(if0.in_ready),  32'd1);
        drive(1'b1, 9'd9, 1'b1, 1'b1);
        chk("bp_held_sum",   32'(if0.out_sum),   32'd9);
        chk("bp_held_count", 32'(if0.out_count), 32'd1);
        drive(1'b0, 9'd0, 1'b0, 1'b1);

        drive(1'b1, 9'd3, 1'b0, 1'b1);
        drive(1'b1, 9'd4, 1'b1, 1'b1);
        chk("flush_valid", 32'(if0.out_valid), 32'd1);
        chk("flush_sum",   32'(if0.out_sum),   32'd7);
        chk("flush_count", 32'(if0.out_count), 32'd2);
        drive(1'b0, 9'd0, 1'b0, 1'b1);
        drive(1'b0, 9'd0, 1'b1, 1'b1);
        chk("flush_empty_valid", 32'(if0.out_valid), 32'd0);
        drive(1'b0, 9'd0, 1'b0, 1'b1);
        chk("flush_empty_valid2", 32'(if0.out_valid), 32'd0);

        drive(1'b1, 9'd6, 1'b0, 1'b1);
        drive(1'b1, 9'd6, 1'b0, 1'b1);
        reset = 1'b1;
        drive(1'b0, 9'd0, 1'b0, 1'b1);
        reset = 1'b0;
        chk("midrst_sum", 32'(if0.out_sum), 32'd0);
        for (int i = 0; i < 4; i++) drive(1'b1, 9'd1, 1'b0, 1'b1);
        chk("midrst_blk_sum",   32'(if0.out_sum),   32'd4);
        chk("midrst_blk_count", 32'(if0.out_count), 32'd4);
        drive(1'b0, 9'd0, 1'b0, 1'b1);

        for (int i = 0; i < 4; i++) drive(1'b1, 9'd1, 1'b0, 1'b0);
        drive(1'b0, 9'd0, 1'b0, 1'b0);
        chk("holdrst_pre_valid", 32'(if0.out_valid), 32'd1);
        reset = 1'b1;
        drive(1'b0, 9'd0, 1'b0, 1'b0);
        reset = 1'b0;
        chk("holdrst_valid", 32'(if0.out_valid), 32'd0);
        chk("holdrst_sum",   32'(if0.out_sum),   32'd0);
        chk("holdrst_ready", 32'(if0.in_ready),  32'd1);

        in_valid = 1'b0;
        for (int c = 0; c < 3000; c++) begin
            reset     = ($urandom_range(0, 399) == 0);
            out_ready = ($urandom_range(0, 3) != 0);
            flush     = ($urandom_range(0, 9) == 0);
            if (!(in_valid && !m_took)) begin
                in_valid = ($urandom_range(0, 9) < 6);
                in_data  = ($urandom_range(0, 1) == 1) ? 9'($urandom_range(400, 511))
                                                       : 9'($urandom_range(0, 511));
            end
            @(posedge clk);
            #1;
        end
        reset = 1'b0;
        drive(1'b0, 9'd0, 1'b0, 1'b1);
        drive(1'b0, 9'd0, 1'b0, 1'b1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
